// File: rtl/downsampling_core.sv
// 3x3 -> 2x2 pooling with stride-1 overlapping 2x2 windows.
// Modes: max, min, floor-average, decimate; one registered stage.
module downsampling_core #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [1:0]         mode,
  input  logic [9*WIDTH-1:0] conv_out,
  output logic [4*WIDTH-1:0] downsampled_out,
  output logic               out_valid
);

  logic [4*WIDTH-1:0] res;
  logic [4*WIDTH-1:0] data_d, data_q;
  logic               valid_d, valid_q;

  for (genvar i = 0; i < 2; i++) begin : g_row
    for (genvar j = 0; j < 2; j++) begin : g_col
      logic [WIDTH-1:0] a, b, c, d;
      logic [WIDTH-1:0] mx0, mx1, mn0, mn1;
      logic [WIDTH-1:0] r;
      logic [WIDTH+1:0] sum;

      assign a = conv_out[(3*i+j)*WIDTH +: WIDTH];
      assign b = conv_out[(3*i+j+1)*WIDTH +: WIDTH];
      assign c = conv_out[(3*(i+1)+j)*WIDTH +: WIDTH];
      assign d = conv_out[(3*(i+1)+j+1)*WIDTH +: WIDTH];

      always_comb begin
        mx0 = (a > b) ? a : b;
        mx1 = (c > d) ? c : d;
        mn0 = (a < b) ? a : b;
        mn1 = (c < d) ? c : d;
        // WIDTH+2 bits holds four maximal elements
        sum = {2'b00, a} + {2'b00, b}
            + {2'b00, c} + {2'b00, d};
        r = a;
        case (mode)
          2'b00:   r = (mx0 > mx1) ? mx0 : mx1;
          2'b01:   r = (mn0 < mn1) ? mn0 : mn1;
          2'b10:   r = sum[WIDTH+1:2];
          default: r = a;
        endcase
      end

      assign res[(2*i+j)*WIDTH +: WIDTH] = r;
    end
  end

  always_comb begin
    valid_d = in_valid;
    data_d  = data_q;
    if (in_valid) data_d = res;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign downsampled_out = data_q;
  assign out_valid       = valid_q;

endmodule

// File: tb/tb_downsampling_core.sv
// Self-checking bench for downsampling_core: directed cases,
// reset behaviour and randomized frames against a reference model.
module tb_downsampling_core;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic [1:0]     mode;
  logic [9*W-1:0] conv_out;
  logic [4*W-1:0] downsampled_out;
  logic           out_valid;

  int total = 0;
  int bad   = 0;

  logic [9*W-1:0] base;

  downsampling_core #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .mode(mode),
    .conv_out(conv_out),
    .downsampled_out(downsampled_out),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9*W-1:0] mk9(
    input int e0, input int e1, input int e2,
    input int e3, input int e4, input int e5,
    input int e6, input int e7, input int e8);
    logic [9*W-1:0] f;
    f = '0;
    f[0*W +: W] = e0[W-1:0]; f[1*W +: W] = e1[W-1:0];
    f[2*W +: W] = e2[W-1:0]; f[3*W +: W] = e3[W-1:0];
    f[4*W +: W] = e4[W-1:0]; f[5*W +: W] = e5[W-1:0];
    f[6*W +: W] = e6[W-1:0]; f[7*W +: W] = e7[W-1:0];
    f[8*W +: W] = e8[W-1:0];
    return f;
  endfunction

  function automatic logic [4*W-1:0] mk4(
    input int o00, input int o01, input int o10, input int o11);
    logic [4*W-1:0] o;
    o = '0;
    o[0*W +: W] = o00[W-1:0]; o[1*W +: W] = o01[W-1:0];
    o[2*W +: W] = o10[W-1:0]; o[3*W +: W] = o11[W-1:0];
    return o;
  endfunction

  // Reference: plain integer pooling over a 3x3 grid
  function automatic logic [4*W-1:0] model(
    input logic [9*W-1:0] f, input logic [1:0] m);
    int g[3][3];
    int win[4];
    int v, s;
    logic [4*W-1:0] o;
    o = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        g[r][c] = int'(f[(3*r+c)*W +: W]);
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        win[0] = g[i][j];   win[1] = g[i][j+1];
        win[2] = g[i+1][j]; win[3] = g[i+1][j+1];
        s = win[0] + win[1] + win[2] + win[3];
        v = win[0];
        for (int k = 1; k < 4; k++) begin
          if (m == 2'd0 && win[k] > v) v = win[k];
          if (m == 2'd1 && win[k] < v) v = win[k];
        end
        if (m == 2'd2) v = s / 4;
        if (m == 2'd3) v = win[0];
        o[(2*i+j)*W +: W] = v[W-1:0];
      end
    end
    return o;
  endfunction

  task automatic test_reset;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    mode     = 2'd0;
    conv_out = mk9(9, 8, 7, 6, 5, 4, 3, 2, 1);
    for (int k = 0; k < 2; k++) begin
      tick();
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL reset_valid cyc%0d got=%b exp=0", k, out_valid);
      end
      total++;
      if (downsampled_out !== '0) begin
        bad++;
        $display("FAIL reset_data cyc%0d got=%h exp=0", k, downsampled_out);
      end
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    tick();
  endtask

  task automatic test_modes;
    logic [4*W-1:0] exp_o [4];
    exp_o[0] = mk4(3, 2, 3, 3);
    exp_o[1] = mk4(0, 0, 0, 0);
    exp_o[2] = mk4(1, 1, 2, 1);
    exp_o[3] = mk4(0, 1, 3, 0);
    for (int m = 0; m < 4; m++) begin
      conv_out = base;
      mode     = 2'(m);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || downsampled_out !== exp_o[m]) begin
        bad++;
        $display("FAIL mode%0d got v=%b d=%h exp v=1 d=%h",
                 m, out_valid, downsampled_out, exp_o[m]);
      end
      tick();
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL mode%0d_drop got v=%b exp v=0", m, out_valid);
      end
    end
  endtask

  task automatic test_avg_no_overflow;
    conv_out = mk9(255, 255, 255, 255, 255, 255, 255, 255, 255);
    mode     = 2'd2;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 ||
        downsampled_out !== mk4(255, 255, 255, 255)) begin
      bad++;
      $display("FAIL avg_255 got v=%b d=%h exp v=1 d=ffffffff",
               out_valid, downsampled_out);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    logic [4*W-1:0] exp_o [4];
    exp_o[0] = mk4(3, 2, 3, 3);
    exp_o[1] = mk4(0, 0, 0, 0);
    exp_o[2] = mk4(1, 1, 2, 1);
    exp_o[3] = mk4(0, 1, 3, 0);
    conv_out = base;
    in_valid = 1'b1;
    for (int m = 0; m < 4; m++) begin
      mode = 2'(m);
      tick();
      total++;
      if (out_valid !== 1'b1 || downsampled_out !== exp_o[m]) begin
        bad++;
        $display("FAIL b2b%0d got v=%b d=%h exp v=1 d=%h",
                 m, out_valid, downsampled_out, exp_o[m]);
      end
    end
    in_valid = 1'b0;
    mode     = 2'd0;
    conv_out = mk9(200, 1, 2, 3, 4, 5, 6, 7, 8);
    tick();
    total++;
    if (out_valid !== 1'b0 || downsampled_out !== exp_o[3]) begin
      bad++;
      $display("FAIL b2b_hold got v=%b d=%h exp v=0 d=%h",
               out_valid, downsampled_out, exp_o[3]);
    end
  endtask

  task automatic test_mid_reset;
    logic [4*W-1:0] held;
    conv_out = base;
    mode     = 2'd0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    held     = downsampled_out;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b1 || downsampled_out !== held) begin
      bad++;
      $display("FAIL async_rst got v=%b d=%h exp v=1 d=%h",
               out_valid, downsampled_out, held);
    end
    tick();
    total++;
    if (out_valid !== 1'b0 || downsampled_out !== '0) begin
      bad++;
      $display("FAIL mid_rst got v=%b d=%h exp v=0 d=0",
               out_valid, downsampled_out);
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b0 || downsampled_out !== '0) begin
      bad++;
      $display("FAIL post_rst got v=%b d=%h exp v=0 d=0",
               out_valid, downsampled_out);
    end
    mode     = 2'd3;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 ||
        downsampled_out !== mk4(0, 1, 3, 0)) begin
      bad++;
      $display("FAIL first_after_rst got v=%b d=%h exp v=1 d=%h",
               out_valid, downsampled_out, mk4(0, 1, 3, 0));
    end
    tick();
  endtask

  task automatic test_random;
    logic [4*W-1:0] exp_d;
    logic           exp_v;
    int             errs;
    exp_d = downsampled_out;
    errs  = 0;
    for (int k = 0; k < 300; k++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      mode     = 2'($urandom_range(0, 3));
      for (int e = 0; e < 9; e++)
        conv_out[e*W +: W] = (k % 7 == 0) ? 8'hFF : 8'($urandom);
      exp_v = in_valid;
      if (in_valid) exp_d = model(conv_out, mode);
      tick();
      total++;
      if (out_valid !== exp_v || downsampled_out !== exp_d) begin
        bad++;
        errs++;
        if (errs < 10)
          $display("FAIL rand%0d got v=%b d=%h exp v=%b d=%h",
                   k, out_valid, downsampled_out, exp_v, exp_d);
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    mode     = 2'd0;
    conv_out = '0;
    base     = mk9(0, 1, 2, 3, 0, 1, 2, 3, 0);
    #1;
    test_reset();
    test_modes();
    test_avg_no_overflow();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/downsampling_core.md
DOWNSAMPLING_CORE -- requirements
Module: downsampling

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8: bit width of each unsigned matrix element.
REQ-002 The module SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 The module SHALL have port in_valid, input, 1 bit: conv_out and mode hold a valid 3x3 frame this cycle.
REQ-005 The module SHALL have port mode, input, 2 bits: pooling operation (00 max, 01 min, 10 average, 11 decimate).
REQ-006 The module SHALL have port conv_out, input, 9*WIDTH bits: 3x3 matrix, row-major; element (r,c) at bits [(3r+c)*WIDTH +: WIDTH].
REQ-007 The module SHALL have port downsampled_out, output, 4*WIDTH bits: 2x2 matrix, row-major; element (i,j) at bits [(2i+j)*WIDTH +: WIDTH].
REQ-008 The module SHALL have port out_valid, output, 1 bit: downsampled_out holds a new result this cycle.

Function
REQ-009 Output element (i,j) SHALL be computed from the 2x2 window of input elements (i,j), (i,j+1), (i+1,j) and (i+1,j+1), using stride 1 with overlapping windows.
REQ-010 In mode 00, each output element SHALL be the unsigned maximum of its 4 window elements.
REQ-011 In mode 01, each output element SHALL be the unsigned minimum of its 4 window elements.
REQ-012 In mode 10, each output element SHALL be floor(sum/4), with the sum computed at WIDTH+2 bits so no intermediate overflow occurs.
REQ-013 In mode 11, each output element SHALL be the top-left window element (i,j).
REQ-014 All elements SHALL be treated as unsigned, and every result SHALL fit in WIDTH bits without saturation logic.
REQ-015 Latency SHALL be exactly 1 cycle: a frame sampled with in_valid=1 at edge N SHALL appear on downsampled_out with out_valid=1 after edge N.
REQ-016 mode and conv_out SHALL be sampled only on edges where in_valid=1; their values SHALL be ignored when in_valid=0.
REQ-017 When in_valid=0, out_valid SHALL deassert on the next edge, and downsampled_out SHALL hold its last value.
REQ-018 Back-to-back frames, with in_valid high on consecutive cycles, SHALL be accepted every cycle with no stall, for a throughput of 1 frame per cycle.
REQ-019 The module SHALL have no backpressure input; the consumer SHALL accept each result in the cycle out_valid=1.
REQ-020 A mode change between frames SHALL take effect on the first frame sampled with the new mode, with no pipeline flush.

Reset
REQ-021 While rst_n=0 at a rising edge, downsampled_out SHALL be cleared to all zeros and out_valid to 0.
REQ-022 Reset SHALL take priority over in_valid: a frame presented in the same cycle as an active reset SHALL be discarded.
REQ-023 Asserting reset mid-stream SHALL discard any pending result, and the first frame after rst_n returns high SHALL produce a normal 1-cycle-latency result.
REQ-024 Outputs SHALL not change asynchronously when rst_n changes between clock edges.

Verification
REQ-025 The bench SHALL check: hold rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0 and downsampled_out=0 throughout.
REQ-026 The bench SHALL check: input [[0,1,2],[3,0,1],[2,3,0]] in mode 00 -> out [[3,2],[3,3]], out_valid=1 one cycle later.
REQ-027 The bench SHALL check: the same input in mode 01 -> [[0,0],[0,0]]; in mode 10 -> [[1,1],[2,1]]; in mode 11 -> [[0,1],[3,0]].
REQ-028 The bench SHALL check: all nine elements at 255 (WIDTH=8) in mode 10 -> [[255,255],[255,255]], with no overflow.
REQ-029 The bench SHALL check: four back-to-back frames, one per mode, with the above input -> four consecutive out_valid pulses with matching results in order; then in_valid=0 -> out_valid=0 and the output holds [[0,1],[3,0]].
REQ-030 The bench SHALL check: rst_n=0 asserted the cycle after a frame is accepted -> out_valid=0 and the output zeroed, with no stale result appearing after reset releases.
